program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader that sits directly upstream of the RISC_V core's fetch stage. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them into IF instruction memory through the core's `rw` / `PC_write` / `instruction_in` / `reset_IF_memory` inputs. It holds the core in reset for the whole load and releases it only after the last word has been written.

## Interface

**Parameters**
- `PC_SIZE`, 10: width of `PC_write`; must match the core.
- `PC_STEP`, 4: address increment between consecutive instruction words.

**Ports** (name, direction, width, meaning)
- `clock`, in, 1: single clock for the block.
- `reset`, in, 1: reset, asynchronous and active-low.
- `load_req`, in, 1: one-cycle start pulse; honoured only in IDLE, DONE or ERROR.
- `byte_valid`, in, 1: host byte available.
- `byte_data`, in, 8: host byte.
- `byte_ready`, out, 1: loader accepts a byte this cycle.
- `rw`, out, 1: IF memory write strobe (1 = write); drives core `rw`.
- `PC_write`, out, PC_SIZE: IF memory write address.
- `instruction_in`, out, 32: IF memory write data.
- `reset_IF_memory`, out, 1: one-cycle IF memory clear.
- `core_reset`, out, 1: active-high hold of core `reset` (1 = core held).
- `done`, out, 1: program loaded, core released.
- `error`, out, 1: the header length was illegal.

## Operation

- **Byte transfer:** a byte transfers on a rising `clock` edge when `byte_valid && byte_ready`. `byte_ready` is 1 only in LEN_LO, LEN_HI and BYTE.
- **Stream format:**
  - A 16-bit word count N, low byte first.
  - Then N words of 4 bytes each, least-significant byte first (byte0 → bits [7:0]).
- **States:**
  - IDLE: `load_req` → CLEAR.
  - CLEAR: one cycle with `reset_IF_memory`=1 and `core_reset`=1 → LEN_LO.
  - LEN_LO: a transfer captures len[7:0] → LEN_HI.
  - LEN_HI: a transfer captures len[15:8]. If N==0 or N > 2^PC_SIZE/PC_STEP (256 at defaults) → ERROR; otherwise → BYTE with byte index=0 and address=0.
  - BYTE: each transfer fills byte[index]. The fourth transfer → WRITE.
  - WRITE: one cycle with `rw`=1, `PC_write`=address and `instruction_in`=assembled word.
    - If words written == N → DONE.
    - Otherwise address += PC_STEP (modulo 2^PC_SIZE), index=0 → BYTE.
  - DONE: `done`=1 and `core_reset`=0. `load_req` → CLEAR.
  - ERROR: `error`=1 and `core_reset` stays 1. `load_req` → CLEAR, which clears `error`.
- **`load_req` outside IDLE/DONE/ERROR:** ignored. A load in progress is never restarted.
- **Output stability:** `PC_write` and `instruction_in` hold their last written values outside WRITE. `rw`=0 in every state except WRITE.
- **Flow control:** stalls (`byte_valid`=0) in any accepting state are unlimited and lose no data.
- **Reset:** reset asserted at any point, including mid-word, aborts the load immediately.
  - All outputs return to their reset values.
  - The partially assembled word is discarded and never written.

## Timing

- **Reset values:** `byte_ready`=0, `rw`=0, `PC_write`=0, `instruction_in`=0, `reset_IF_memory`=0, `core_reset`=1, `done`=0, `error`=0, state=IDLE. The core therefore stays held after reset until a successful load.
- **Cycle after the accepted `load_req`:** CLEAR (`reset_IF_memory` high for exactly 1 cycle).
- **`rw` pulse:** asserted in the cycle after the edge that accepted a word's 4th byte; lasts exactly 1 cycle per word.
- **Throughput:** at most 1 word per 5 cycles, since `byte_ready` is 0 during WRITE.
- **DONE:** `done`=1 and `core_reset`=0 in the cycle after the last WRITE.
- **ERROR:** `error`=1 in the cycle after LEN_HI accepts an illegal length.
- **Write ordering:** the core samples the IF memory write at the `clock` edge ending WRITE. All writes complete before `core_reset` falls.

## Structure

- **Shared package `riscv_pkg`:**
  - State enum (IDLE, CLEAR, LEN_LO, LEN_HI, BYTE, WRITE, DONE, ERROR).
  - `RW_WRITE`=1'b1 and `RW_READ`=1'b0 constants.
  - Default `PC_STEP`.
  - `MAX_WORDS` function of `PC_SIZE` and `PC_STEP`.
- **Sub-module `word_assembler`:**
  - Takes a 2-bit byte index plus the accepted byte and a clear input.
  - Produces the 32-bit word and a `full` flag after byte 3.
- **FSM and counters** (address, words written, length) live in `program_loader`.

## Test plan

- **Basic 2-word load:** after reset, pulse `load_req`; stream 02 00, 13 00 00 00, 93 00 10 00 with `byte_valid` held high.
  - `reset_IF_memory` pulses once.
  - `rw` pulses with PC_write=0 / instruction_in=0x00000013, then PC_write=4 / instruction_in=0x00100093.
  - Then `done`=1, `core_reset`=0.
- **Back-pressure:** same stream with `byte_valid` toggled randomly.
  - Identical writes.
  - No byte accepted while `byte_ready`=0.
  - `rw` stays a single-cycle pulse per word.
- **Length errors:**
  - Header 00 00 → `error`=1, no `rw`, `core_reset`=1.
  - Header 01 01 (257) → same.
  - A subsequent `load_req` with a legal stream clears `error` and completes.
- **Maximum length:** N=256 words.
  - The last write is at PC_write=0x3FC (1020).
  - No wrap before DONE.
  - `done`=1.
- **Reset mid-load:** assert reset after the 2nd byte of word 1.
  - All outputs return to reset values and no write of word 1 occurs.
  - A new load then writes from address 0.
- **Ignored start:** `load_req` pulsed during BYTE has no effect; the in-progress load completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the boot-time program loader.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LEN_LO,
    LEN_HI,
    BYTE,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned DEFAULT_PC_STEP = 4;

  // Number of instruction words that fit in the IF memory address space.
  function automatic int unsigned MAX_WORDS(input int unsigned pc_size,
                                            input int unsigned pc_step);
    return (32'd1 << pc_size) / pc_step;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word packer; byte 0 lands in bits [7:0].
module word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  index,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        full
);

  logic [31:0] word_q;

  // Byte lane write; clear wipes any partial word between loads/words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
    end else if (clear) begin
      word_q <= '0;
    end else if (load) begin
      word_q[{index, 3'b000} +: 8] <= data;
    end
  end

  // Full when the most significant byte is being accepted.
  always_comb begin
    word = word_q;
    full = load && (index == 2'd3);
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into IF instruction memory, holding
// the core in reset until every word has been written.
module program_loader
  import riscv_pkg::*;
#(
  parameter int unsigned PC_SIZE = 10,
  parameter int unsigned PC_STEP = DEFAULT_PC_STEP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_req,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               rw,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               reset_IF_memory,
  output logic               core_reset,
  output logic               done,
  output logic               error
);

  localparam int unsigned MAXW = MAX_WORDS(PC_SIZE, PC_STEP);

  loader_state_t      state, next_state;
  logic [7:0]         len_lo;
  logic [15:0]        len;
  logic [15:0]        wcount;
  logic [PC_SIZE-1:0] addr;
  logic [PC_SIZE-1:0] pc_hold;
  logic [31:0]        inst_hold;
  logic [1:0]         idx;
  logic               xfer;
  logic [15:0]        hdr_len;
  logic               len_bad;
  logic               last_word;
  logic [31:0]        asm_word;
  logic               asm_full;

  // Handshake and header decode.
  always_comb begin
    xfer      = byte_valid && byte_ready;
    hdr_len   = {byte_data, len_lo};
    len_bad   = (hdr_len == '0) || (32'(hdr_len) > MAXW);
    last_word = ((wcount + 16'd1) == len);
  end

  word_assembler u_asm (
    .clock (clock),
    .reset (reset),
    .clear ((state == CLEAR) || (state == WRITE)),
    .load  (xfer && (state == BYTE)),
    .index (idx),
    .data  (byte_data),
    .word  (asm_word),
    .full  (asm_full)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_req) next_state = CLEAR;
      CLEAR:   next_state = LEN_LO;
      LEN_LO:  if (xfer) next_state = LEN_HI;
      LEN_HI:  if (xfer) next_state = len_bad ? ERROR : BYTE;
      BYTE:    if (asm_full) next_state = WRITE;
      WRITE:   next_state = last_word ? DONE : BYTE;
      DONE:    if (load_req) next_state = CLEAR;
      ERROR:   if (load_req) next_state = CLEAR;
      default: next_state = IDLE;
    endcase
  end

  // Length, address, word counter, byte index and held write outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_lo    <= '0;
      len       <= '0;
      wcount    <= '0;
      addr      <= '0;
      pc_hold   <= '0;
      inst_hold <= '0;
      idx       <= '0;
    end else begin
      case (state)
        LEN_LO: if (xfer) len_lo <= byte_data;
        LEN_HI: begin
          if (xfer) begin
            len    <= hdr_len;
            addr   <= '0;
            wcount <= '0;
            idx    <= '0;
          end
        end
        BYTE:   if (xfer) idx <= idx + 2'd1;
        WRITE: begin
          pc_hold   <= addr;
          inst_hold <= asm_word;
          wcount    <= wcount + 16'd1;
          addr      <= addr + PC_SIZE'(PC_STEP);
          idx       <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs; write address/data show live values in WRITE and hold otherwise.
  always_comb begin
    byte_ready      = (state == LEN_LO) || (state == LEN_HI) || (state == BYTE);
    rw              = (state == WRITE) ? RW_WRITE : RW_READ;
    PC_write        = (state == WRITE) ? addr : pc_hold;
    instruction_in  = (state == WRITE) ? asm_word : inst_hold;
    reset_IF_memory = (state == CLEAR);
    core_reset      = (state != DONE);
    done            = (state == DONE);
    error           = (state == ERROR);
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of load scenarios plus hand sequences,
// with a write scoreboard checked on every rw pulse.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        rw;
  logic [9:0]  PC_write;
  logic [31:0] instruction_in;
  logic        reset_IF_memory;
  logic        core_reset;
  logic        done;
  logic        error;

  program_loader #(.PC_SIZE(10), .PC_STEP(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .load_req        (load_req),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .rw              (rw),
    .PC_write        (PC_write),
    .instruction_in  (instruction_in),
    .reset_IF_memory (reset_IF_memory),
    .core_reset      (core_reset),
    .done            (done),
    .error           (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    bit          bp;
    bit          exp_err;
  } vec_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  clr_cnt = 0;
  logic rw_prev = 1'b0;
  wr_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write is popped against the expected queue.
  always @(negedge clock) begin
    if (reset) begin
      if (reset_IF_memory) clr_cnt++;
      if (rw) begin
        check("rw_single_cycle", {31'd0, rw_prev}, 32'd0);
        check("rw_core_held", {31'd0, core_reset}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got pc %h data %h expected no write", PC_write, instruction_in);
        end else begin
          mon_e = exp_q.pop_front();
          check("PC_write", {22'd0, PC_write}, {22'd0, mon_e.pc});
          check("instruction_in", instruction_in, mon_e.data);
        end
      end
      rw_prev = rw;
    end else begin
      rw_prev = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int bound;
    if (bp) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        @(negedge clock);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    bound = 0;
    while (!byte_ready && bound < 100) begin
      @(negedge clock);
      bound++;
    end
    if (bound >= 100) begin
      check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit bp);
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], bp);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    check("clear_reset_IF_memory", {31'd0, reset_IF_memory}, 32'd1);
    check("clear_core_reset", {31'd0, core_reset}, 32'd1);
    check("clear_error_low", {31'd0, error}, 32'd0);
  endtask

  task automatic do_load(input logic [15:0] n, input bit bp, input bit exp_err);
    logic [31:0] d;
    wr_t e;
    int clr0;
    clr0 = clr_cnt;
    pulse_load();
    send_byte(n[7:0], bp);
    send_byte(n[15:8], bp);
    if (exp_err) begin
      check("err_error", {31'd0, error}, 32'd1);
      check("err_core_reset", {31'd0, core_reset}, 32'd1);
      check("err_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clock);
      check("err_sticky", {31'd0, error}, 32'd1);
      check("err_no_write", exp_q.size(), 32'd0);
    end else begin
      for (int unsigned i = 0; i < 32'(n); i++) begin
        d      = $urandom;
        e.pc   = 10'(i * 4);
        e.data = d;
        exp_q.push_back(e);
        send_word(d, bp);
      end
      @(negedge clock);
      check("done_flag", {31'd0, done}, 32'd1);
      check("done_core_released", {31'd0, core_reset}, 32'd0);
      check("done_error_low", {31'd0, error}, 32'd0);
      check("all_writes_seen", exp_q.size(), 32'd0);
    end
    check("clear_pulse_count", 32'(clr_cnt - clr0), 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    wr_t e;
    int clr0;
    vecs[0] = '{n: 16'd2,   bp: 1'b0, exp_err: 1'b0};
    vecs[1] = '{n: 16'd2,   bp: 1'b1, exp_err: 1'b0};
    vecs[2] = '{n: 16'd0,   bp: 1'b0, exp_err: 1'b1};
    vecs[3] = '{n: 16'd3,   bp: 1'b1, exp_err: 1'b0};
    vecs[4] = '{n: 16'd257, bp: 1'b1, exp_err: 1'b1};
    vecs[5] = '{n: 16'd1,   bp: 1'b0, exp_err: 1'b0};
    vecs[6] = '{n: 16'd256, bp: 1'b0, exp_err: 1'b0};

    repeat (3) @(negedge clock);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd0);
    check("rst_PC_write", {22'd0, PC_write}, 32'd0);
    check("rst_instruction_in", instruction_in, 32'd0);
    check("rst_reset_IF_memory", {31'd0, reset_IF_memory}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Basic load with the fixed two-instruction image.
    clr0 = clr_cnt;
    pulse_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    e = '{pc: 10'd0, data: 32'h0000_0013};
    exp_q.push_back(e);
    send_word(32'h0000_0013, 1'b0);
    e = '{pc: 10'd4, data: 32'h0010_0093};
    exp_q.push_back(e);
    send_word(32'h0010_0093, 1'b0);
    @(negedge clock);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_core_reset", {31'd0, core_reset}, 32'd0);
    check("basic_writes_seen", exp_q.size(), 32'd0);
    check("basic_clear_pulses", 32'(clr_cnt - clr0), 32'd1);
    check("basic_hold_pc", {22'd0, PC_write}, 32'd4);
    check("basic_hold_data", instruction_in, 32'h0010_0093);

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].n, vecs[i].bp, vecs[i].exp_err);
    end

    // load_req during BYTE must be ignored.
    pulse_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    e = '{pc: 10'd0, data: 32'hCAFE_F00D};
    exp_q.push_back(e);
    send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    check("ign_byte_ready", {31'd0, byte_ready}, 32'd1);
    check("ign_no_clear", {31'd0, reset_IF_memory}, 32'd0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b0);
    @(negedge clock);
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_writes_seen", exp_q.size(), 32'd0);

    // Reset after the second byte of word 1 discards that word.
    pulse_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    e = '{pc: 10'd0, data: 32'h1234_5678};
    exp_q.push_back(e);
    send_word(32'h1234_5678, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rw", {31'd0, rw}, 32'd0);
    check("mid_PC_write", {22'd0, PC_write}, 32'd0);
    check("mid_instruction_in", instruction_in, 32'd0);
    check("mid_reset_IF_memory", {31'd0, reset_IF_memory}, 32'd0);
    check("mid_core_reset", {31'd0, core_reset}, 32'd1);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_error", {31'd0, error}, 32'd0);
    check("mid_word0_written", exp_q.size(), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_idle_after", {31'd0, byte_ready}, 32'd0);
    do_load(16'd2, 1'b1, 1'b0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
